// File: rtl/btle_rx_pdu_reader.sv
// BLE receiver PDU drain stage: latches frame status, reads PDU octets from memory, streams them out.
// Optional trailing status octet enabled by defining BTLE_RX_PDU_READER_STATUS_OCTET_EN.
module btle_rx_pdu_reader #(
    parameter int unsigned DROP_BAD_CRC   = 1,
    parameter int unsigned COUNTER_WIDTH  = 16,
    parameter int unsigned MEM_ADDR_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hit_flag,
    input  logic                      decode_end,
    input  logic                      crc_ok,
    input  logic [2:0]                best_phase,
    input  logic [6:0]                payload_length,
    output logic [MEM_ADDR_WIDTH-1:0] pdu_octet_mem_addr,
    input  logic [7:0]                pdu_octet_mem_data,
    output logic [7:0]                m_octet,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      busy,
    output logic                      frame_drop,
    output logic                      overrun,
    output logic [COUNTER_WIDTH-1:0]  frame_ok_count,
    output logic [COUNTER_WIDTH-1:0]  frame_bad_count
);

`ifdef BTLE_RX_PDU_READER_STATUS_OCTET_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    localparam int unsigned DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam int unsigned TW    = MEM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   total_q, ptr_q, total_c, total_x, last_x, rd_idx;
    logic [8:0]      len_plus2;
    logic            clamp_c, clamp_q, crc_q;
    logic [2:0]      phase_q;
    logic [1:0]      count_q;
    logic [8:0]      fifo_q [2];
    logic            pend_valid_q, pend_last_q, pend_status_q;
    logic            pop, frame_done, can_accept, take, fetch_issue, issue, rd_last;
    logic [2:0]      occ;
    logic [7:0]      status_octet;
    logic [8:0]      push_entry;

    always_comb begin
        len_plus2 = {2'b00, payload_length} + 9'd2;
        clamp_c   = 32'(len_plus2) > DEPTH;
        total_c   = clamp_c ? TW'(DEPTH) : TW'(len_plus2);
    end

    assign busy    = (state_q != IDLE);
    assign m_valid = (count_q != 2'd0);
    assign m_octet = fifo_q[0][7:0];
    assign m_last  = m_valid && fifo_q[0][8];
    assign pop     = m_valid && m_ready;

    // A frame may be taken in the same cycle the previous one's final octet leaves.
    assign frame_done = (state_q == DRAIN) && pop && fifo_q[0][8];
    assign can_accept = (state_q == IDLE) || frame_done;
    assign take       = decode_end && can_accept && (crc_ok || DROP_BAD_CRC == 0);

    // Occupancy after this cycle's pop keeps the stream bubble-free with m_ready high.
    assign occ         = {1'b0, count_q} + {2'b00, pend_valid_q} - {2'b00, pop};
    assign fetch_issue = (state_q == FETCH) && (occ < 3'd2);
    assign issue       = take || fetch_issue;
    assign total_x     = take ? total_c : total_q;
    assign last_x      = STATUS_EN ? total_x : total_x - TW'(1);
    assign rd_idx      = take ? '0 : ptr_q;
    assign rd_last     = (rd_idx == last_x);

    assign status_octet = {crc_q, clamp_q, 3'b000, phase_q};
    assign push_entry   = pend_status_q ? {pend_last_q, status_octet}
                                        : {pend_last_q, pdu_octet_mem_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = FETCH;
            FETCH:   if (fetch_issue && rd_last) state_d = DRAIN;
            DRAIN:   if (frame_done) state_d = take ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q            <= '0;
            clamp_q            <= 1'b0;
            crc_q              <= 1'b0;
            phase_q            <= '0;
            ptr_q              <= '0;
            pend_valid_q       <= 1'b0;
            pend_last_q        <= 1'b0;
            pend_status_q      <= 1'b0;
            pdu_octet_mem_addr <= '0;
        end else begin
            if (take) begin
                total_q <= total_c;
                clamp_q <= clamp_c;
                crc_q   <= crc_ok;
                phase_q <= best_phase;
            end
            pend_valid_q <= issue;
            if (issue) begin
                ptr_q         <= rd_idx + TW'(1);
                pend_last_q   <= rd_last;
                pend_status_q <= (rd_idx == total_x);
                if (rd_idx != total_x)
                    pdu_octet_mem_addr <= rd_idx[MEM_ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            unique case ({pop, pend_valid_q})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        fifo_q[0] <= push_entry;
                    end else begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= push_entry;
                    end
                end
                2'b10: begin
                    fifo_q[0] <= fifo_q[1];
                    count_q   <= count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) fifo_q[0] <= push_entry;
                    else                 fifo_q[1] <= push_entry;
                    count_q <= count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok_count  <= '0;
            frame_bad_count <= '0;
            frame_drop      <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            if (decode_end) begin
                if (crc_ok) begin
                    if (frame_ok_count != '1)
                        frame_ok_count <= frame_ok_count + COUNTER_WIDTH'(1);
                end else if (frame_bad_count != '1) begin
                    frame_bad_count <= frame_bad_count + COUNTER_WIDTH'(1);
                end
            end
            frame_drop <= decode_end && busy && !can_accept;
            overrun    <= hit_flag && busy;
        end
    end

endmodule
